fir_interp: RTL and testbench

FIR_INTERP -- requirements
Module: fir_interp

---
 rtl/fir_interp.sv | 89 ++++++++
 tb/tb_fir_interp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_interp.sv
// fir_interp: polyphase FIR interpolator producing INTERPOLATION outputs per input sample.
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   x_in         signed sample at the head of the upstream fall-through FIFO
//   x_in_rd_en   pop strobe to the upstream FIFO (combinational, READ state only)
//   x_in_empty   upstream FIFO empty
//   y_out        registered signed interpolated sample, valid while y_out_wr_en is high
//   y_out_wr_en  push strobe to the downstream FIFO (combinational, WRITE state only)
//   y_out_full   downstream FIFO full
// Build option: define FIR_INTERP_GAIN_COMP_EN to scale y_out by INTERPOLATION
// (shift left by log2(INTERPOLATION), wrapping) to undo the zero-stuffing loss.
module fir_interp #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS = 32,
  parameter int INTERPOLATION = 8,
  parameter int FRAC_BITS = 10,
  parameter logic [0:TAPS-1][31:0] COEFF = '0
) (
  input  logic clock,
  input  logic reset,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic x_in_rd_en,
  input  logic x_in_empty,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic y_out_wr_en,
  input  logic y_out_full
);
  localparam int PH = TAPS / INTERPOLATION;
  localparam int PW = $clog2(INTERPOLATION);
  localparam int MW = PH > 1 ? $clog2(PH) : 1;
  typedef enum logic [1:0] {READ = 2'd0, COMPUTE = 2'd1, WRITE = 2'd2} state_t;
  state_t state, next;
  logic [PW-1:0] p;
  logic [MW-1:0] m;
  logic signed [DATA_WIDTH-1:0] hist [PH];
  logic [DATA_WIDTH-1:0] acc, acc_next, y_next;
  logic signed [63:0] prod;
  logic last_tap, last_phase;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= READ;
    else state <= next;
  always_comb begin
    last_tap = m == MW'(PH - 1);
    last_phase = p == PW'(INTERPOLATION - 1);
    x_in_rd_en = state == READ && !x_in_empty;
    y_out_wr_en = state == WRITE && !y_out_full;
    next = state == READ ? (x_in_empty ? READ : COMPUTE) :
           state == COMPUTE ? (last_tap ? WRITE : COMPUTE) :
           state == WRITE ? (y_out_full ? WRITE : last_phase ? READ : COMPUTE) : READ;
  end
  // With INTERPOLATION a power of two, p + m*INTERPOLATION is just {m, p}.
  always_comb begin
    prod = 64'($signed(COEFF[{m, p}])) * 64'(hist[m]);
    acc_next = acc + DATA_WIDTH'(prod >>> FRAC_BITS);
`ifdef FIR_INTERP_GAIN_COMP_EN
    y_next = acc_next << PW;
`else
    y_next = acc_next;
`endif
  end
  // y_out is loaded on the final MAC so it is already valid in the WRITE cycle.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < PH; i++) hist[i] <= '0;
      acc <= '0;
      p <= '0;
      m <= '0;
      y_out <= '0;
    end else begin
      if (x_in_rd_en) begin
        for (int i = PH - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= x_in;
        p <= '0;
        m <= '0;
        acc <= '0;
      end
      if (state == COMPUTE) begin
        acc <= acc_next;
        m <= last_tap ? m : m + 1'b1;
        if (last_tap) y_out <= y_next;
      end
      if (y_out_wr_en && !last_phase) begin
        p <= p + 1'b1;
        m <= '0;
        acc <= '0;
      end
    end
endmodule

// File: tb/tb_fir_interp.sv
// tb_fir_interp: randomized self-checking bench for fir_interp against a polyphase sum model.
module tb_fir_interp;
  localparam int L = 8;
  localparam int TAPS = 32;
  localparam int PH = TAPS / L;
  localparam int FRAC = 10;
`ifdef FIR_INTERP_GAIN_COMP_EN
  localparam int G = 3;
`else
  localparam int G = 0;
`endif
  function automatic logic [0:TAPS-1][31:0] mk_ca();
    for (int i = 0; i < TAPS; i++)
      mk_ca[i] = i % 7 == 3 ? 32'h7FFFFFFF : i % 5 == 1 ? 32'h80000001 : 32'(i * 40503 - 600000);
  endfunction
  localparam logic [0:TAPS-1][31:0] CA = mk_ca();
  localparam logic [0:TAPS-1][31:0] CB = {TAPS{32'd1024}};
  logic clock, reset, x_in_empty, y_out_full;
  logic [31:0] x_in;
  logic [1:0] rd, wr;
  logic [31:0] y [2];
  int total, bad, cyc, pop_cyc, nout, emode;
  bit fmode, hold_full, capture, lat_chk, tog;
  logic [31:0] src [$];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] cap [$];
  logic [31:0] mh [PH];
  logic [31:0] last_y1;
  fir_interp #(.DATA_WIDTH(32), .TAPS(TAPS), .INTERPOLATION(L), .FRAC_BITS(FRAC), .COEFF(CA)) u0 (
    .clock(clock), .reset(reset), .x_in(x_in), .x_in_rd_en(rd[0]), .x_in_empty(x_in_empty),
    .y_out(y[0]), .y_out_wr_en(wr[0]), .y_out_full(y_out_full));
  fir_interp #(.DATA_WIDTH(32), .TAPS(TAPS), .INTERPOLATION(L), .FRAC_BITS(FRAC), .COEFF(CB)) u1 (
    .clock(clock), .reset(reset), .x_in(x_in), .x_in_rd_en(rd[1]), .x_in_empty(x_in_empty),
    .y_out(y[1]), .y_out_wr_en(wr[1]), .y_out_full(y_out_full));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] term(input logic [31:0] c, input logic [31:0] h);
    longint pr;
    pr = longint'($signed(c)) * longint'($signed(h));
    return 32'(pr >>> FRAC);
  endfunction
  // Each popped sample yields L outputs: phase p sums coefficients p, p+L, p+2L, ... over the history.
  task automatic model_push(input logic [31:0] x);
    logic [31:0] sa, sb;
    for (int i = PH - 1; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = x;
    for (int ph = 0; ph < L; ph++) begin
      sa = 0;
      sb = 0;
      for (int k = 0; k < PH; k++) begin
        sa += term(CA[ph + k * L], mh[k]);
        sb += term(CB[ph + k * L], mh[k]);
      end
      q0.push_back(sa << G);
      q1.push_back(sb << G);
    end
  endtask
  function automatic logic [31:0] rv();
    int s;
    s = $urandom_range(0, 5);
    return s == 0 ? 32'h7FFFFFFF : s == 1 ? 32'h80000000 : $urandom;
  endfunction
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  initial begin
    x_in = 0;
    x_in_empty = 1;
    y_out_full = 0;
    forever begin
      @(posedge clock);
      #1;
      x_in_empty = src.size() == 0 || (emode == 1 ? tog : emode == 2 ? $urandom_range(0, 2) == 0 : 1'b0);
      tog = !tog;
      x_in = src.size() != 0 ? src[0] : 32'h0;
      y_out_full = hold_full || (fmode && $urandom_range(0, 3) == 0);
    end
  end
  initial forever begin
    @(negedge clock);
    cyc++;
    if (!reset) begin
      chk("excl", {30'b0, rd[0] & wr[0]}, 0);
      chk("rd_match", rd[1], rd[0]);
      chk("wr_match", wr[1], wr[0]);
      if (rd[0]) begin
        chk("pop_empty", x_in_empty, 0);
        chk("pop_early", q0.size(), 0);
        model_push(src.size() != 0 ? src.pop_front() : x_in);
        pop_cyc = cyc;
        nout = 0;
      end
      if (wr[0]) begin
        chk("wr_full", y_out_full, 0);
        chk("y_queued", q0.size() != 0 && q1.size() != 0, 1);
        if (q0.size() != 0) chk("y0", y[0], q0.pop_front());
        if (q1.size() != 0) chk("y1", y[1], q1.pop_front());
        if (lat_chk && nout == 0) chk("latency", cyc - pop_cyc, PH + 1);
        if (capture) cap.push_back(y[0]);
        last_y1 = y[1];
        nout++;
      end
    end
  end
  task automatic drain();
    for (int i = 0; i < 5000 && (src.size() != 0 || q0.size() != 0 || q1.size() != 0); i++) begin
      @(negedge clock);
      #1;
    end
    chk("drain", src.size() + q0.size() + q1.size(), 0);
  endtask
  task automatic wait_nout(input int n);
    for (int i = 0; i < 2000 && nout != n; i++) begin
      @(negedge clock);
      #1;
    end
    chk("wait_nout", nout, n);
  endtask
  task automatic check_impulse(input string tag);
    logic [31:0] e;
    chk({tag, "_n"}, cap.size(), TAPS);
    for (int i = 0; i < TAPS && i < cap.size(); i++) begin
      e = CA[i] << G;
      chk(tag, cap[i], e);
    end
  endtask
  initial begin
    logic [31:0] ys;
    logic [31:0] e;
    reset = 0;
    for (int i = 0; i < PH; i++) mh[i] = 0;
    #1 reset = 1;
    #2;
    chk("rst_y0", y[0], 0);
    chk("rst_y1", y[1], 0);
    chk("rst_rd", rd, 0);
    chk("rst_wr", wr, 0);
    #20 reset = 0;
    src = '{1024, 0, 0, 0};
    capture = 1;
    lat_chk = 1;
    drain();
    capture = 0;
    lat_chk = 0;
    check_impulse("impulse");
    for (int i = 0; i < 8; i++) src.push_back(1024);
    drain();
    e = 4096 << G;
    chk("const", last_y1, e);
    src = '{rv(), rv()};
    wait_nout(3);
    hold_full = 1;
    repeat (PH + 2) @(negedge clock);
    #1;
    ys = y[0];
    chk("stall_y", ys, q0.size() != 0 ? q0[0] : 32'hx);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      #1;
      chk("stall_hold", y[0], ys);
      chk("stall_wr", wr[0], 0);
    end
    hold_full = 0;
    drain();
    emode = 1;
    src = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, rv(), rv(), rv()};
    drain();
    emode = 0;
    src = '{rv()};
    wait_nout(2);
    repeat (2) @(negedge clock);
    #2 reset = 1;
    #1;
    chk("mid_rst_y", y[0], 0);
    chk("mid_rst_rd", rd, 0);
    chk("mid_rst_wr", wr, 0);
    src.delete();
    q0.delete();
    q1.delete();
    cap.delete();
    for (int i = 0; i < PH; i++) mh[i] = 0;
    repeat (2) @(negedge clock);
    #2 reset = 0;
    src = '{1024, 0, 0, 0};
    capture = 1;
    @(negedge clock);
    #1;
    chk("first_pop", rd[0], 1);
    drain();
    capture = 0;
    check_impulse("impulse_after_rst");
    emode = 2;
    fmode = 1;
    for (int i = 0; i < 20; i++) src.push_back(rv());
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
